// File: rtl/csa_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder: one 4-bit carry-select slice is reused over NSLICE cycles,
// with the inter-slice carry held in a flop. Valid/ready handshakes on both sides.
module csa_seq_adder_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NSLICE = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, partial, partial_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       a4, b4;
  logic [4:0]       cand0, cand1, slice_res;
  logic             accept, last;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Inputs are ignored outside IDLE and out_ready is ignored outside DONE.
  assign accept = in_valid & in_ready;
  assign last   = (idx == IW'(NSLICE - 1));

  // Carry-select slice: both carry-in candidates are formed, the registered carry picks one.
  always_comb begin
    a4           = a_q[4*idx +: 4];
    b4           = b_q[4*idx +: 4];
    cand0        = {1'b0, a4} + {1'b0, b4};
    cand1        = cand0 + 5'd1;
    slice_res    = carry ? cand1 : cand0;
    partial_next = partial;
    partial_next[4*idx +: 4] = slice_res[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // sum/cout change only when the last slice completes, so partial values never leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      partial <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          partial <= partial_next;
          carry   <= slice_res[4];
          idx     <= idx + IW'(1);
          if (last) begin
            sum  <= partial_next;
            cout <= slice_res[4];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_adder_ctrl.sv
// Bench for csa_seq_adder_ctrl: directed vector table, multi-cycle corner sequences and
// randomized traffic on a 16-bit and an 8-bit instance, checked through expected queues.
module tb_csa_seq_adder_ctrl;

  localparam int W  = 16;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  logic          in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [W8-1:0] a8, b8, sum8;

  csa_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  csa_seq_adder_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8), .busy(busy8)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp8_q[$];
  int           hand_q[$];
  logic [W-1:0] prev_sum = '0;
  logic [16:0]  m16;
  logic [8:0]   m8;
  logic [31:0]  e16, e8;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard, 16-bit: model pushed on accept, popped on result handoff.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        m16 = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        exp_q.push_back({15'b0, m16});
      end
      if (out_valid && out_ready) begin
        hand_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("sb16_unexpected", {15'b0, cout, sum}, 32'hFFFF_FFFF);
        end else begin
          e16 = exp_q.pop_front();
          check("sb16_result", {15'b0, cout, sum}, e16);
        end
      end
    end
  end

  // Scoreboard, 8-bit.
  always @(negedge clk) begin
    if (rst) begin
      exp8_q.delete();
    end else begin
      if (in_valid8 && in_ready8) begin
        m8 = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
        exp8_q.push_back({23'b0, m8});
      end
      if (out_valid8 && out_ready8) begin
        if (exp8_q.size() == 0) begin
          check("sb8_unexpected", {23'b0, cout8, sum8}, 32'hFFFF_FFFF);
        end else begin
          e8 = exp8_q.pop_front();
          check("sb8_result", {23'b0, cout8, sum8}, e8);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One add with exact latency, hold and handoff checks; optionally scrambles inputs during RUN.
  task automatic run_vec(input vec_t v, input bit scramble);
    int n;
    wait_ready();
    a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      check("sum_hold_run", 32'(sum), 32'(prev_sum));
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd4);
    check("out_valid", 32'(out_valid), 32'd1);
    check("vec_sum", 32'(sum), 32'(v.exp_sum));
    check("vec_cout", 32'(cout), 32'(v.exp_cout));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_return", 32'(in_ready), 32'd1);
    prev_sum = v.exp_sum;
  endtask

  initial begin
    vec_t vecs[9];
    vec_t v;
    logic [W-1:0] ops_a[3], ops_b[3];
    logic         ops_c[3];
    int n, sent, acc16, acc8;
    bit ok16, ok8;

    vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[5] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], (i % 2) == 0);

    // Backpressure: DONE held for 10 cycles with in_valid pulses that must be ignored.
    wait_ready();
    a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(n);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h0000);
      check("bp_cout", 32'(cout), 32'd1);
      in_valid = (i % 2 == 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_sum_kept_idle", 32'(sum), 32'h0000);
    check("bp_cout_kept_idle", 32'(cout), 32'd1);
    prev_sum = 16'h0000;

    // Reset during the second RUN cycle aborts the add.
    wait_ready();
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    prev_sum = '0;
    v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    run_vec(v, 1'b0);

    // Back-to-back: in_valid held high over three operand sets with out_ready high.
    ops_a[0] = 16'h1111; ops_b[0] = 16'h2222; ops_c[0] = 1'b1;
    ops_a[1] = 16'hF00F; ops_b[1] = 16'h0FF1; ops_c[1] = 1'b0;
    ops_a[2] = 16'hC3C3; ops_b[2] = 16'h3C3C; ops_c[2] = 1'b1;
    hand_q.delete();
    out_ready = 1'b1;
    sent = 0; n = 0;
    while (sent < 3 && n < 60) begin
      a = ops_a[sent]; b = ops_b[sent]; cin = ops_c[sent]; in_valid = 1'b1;
      ok16 = in_ready;
      @(posedge clk); #1;
      if (ok16) sent++;
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("b2b_sent", 32'(sent), 32'd3);
    check("b2b_results", 32'(hand_q.size()), 32'd3);
    if (hand_q.size() == 3) begin
      check("b2b_spacing_1", 32'(hand_q[1] - hand_q[0]), 32'd6);
      check("b2b_spacing_2", 32'(hand_q[2] - hand_q[1]), 32'd6);
    end
    check("b2b_last_sum", 32'(sum), 32'h0000);
    check("b2b_last_cout", 32'(cout), 32'd1);

    // Random traffic on both widths with random stalls on both sides.
    acc16 = 0; acc8 = 0; n = 0;
    while ((acc16 < 1000 || acc8 < 1000) && n < 30000) begin
      in_valid  = (acc16 < 1000) && ($urandom_range(0, 3) != 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid8 = (acc8 < 1000) && ($urandom_range(0, 3) != 0);
      a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
      out_ready8 = ($urandom_range(0, 3) != 0);
      ok16 = in_valid && in_ready;
      ok8  = in_valid8 && in_ready8;
      @(posedge clk); #1;
      if (ok16) acc16++;
      if (ok8) acc8++;
      n++;
    end
    in_valid = 1'b0; in_valid8 = 1'b0;
    out_ready = 1'b1; out_ready8 = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0; out_ready8 = 1'b0;
    check("rand16_accepted", 32'(acc16), 32'd1000);
    check("rand8_accepted", 32'(acc8), 32'd1000);
    check("rand16_drained", 32'(exp_q.size()), 32'd0);
    check("rand8_drained", 32'(exp8_q.size()), 32'd0);
    check("final_idle16", 32'(in_ready), 32'd1);
    check("final_idle8", 32'(in_ready8), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
